dm_responder: RTL
=================

// Module: dm_responder
// PURPOSE
//  Data-memory responder: the memory end of the CPU load/store interface.
//  Accepts one request at a time over a valid/ready handshake and inserts a
//  programmable number of wait states. Commits byte-enabled writes or returns
//  the read word over a valid/ready response channel.
//  Sits behind the datapath in place of the single-cycle DM, so multi-cycle and
//  pipelined cores can stall on memory.
// PARAMETERS
//  DEPTH_WORDS  1024        number of 32-bit words stored; power of two
//  LATENCY      2           wait states between accept and response, 0..15
//  BASE_ADDR    32'h0       byte address of word 0
// PORTS
//  clk         in   1   system clock; all state changes on its rising edge
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_be      in   4   byte enables for stores; bit i covers wdata[8i+7:8i]
//  req_wdata   in   32  store data
//  req_pc      in   32  PC of the issuing instruction; used only for the store log
//  resp_valid  out  1   response present
//  resp_ready  in   1   consumer takes the response
//  resp_rdata  out  32  load data; 0 for stores and for errored requests
//  resp_err    out  1   request was out of range or misaligned
// BEHAVIOUR
//  Reset:
//   - Returns to IDLE. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//   - All memory words are cleared to 0.
//   - Any in-flight request is dropped and never committed.
//  States:
//   IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/be/wdata/pc and
//         load wait_cnt=LATENCY. Go to WAIT if LATENCY>0, else to COMMIT.
//   WAIT: req_ready=0. wait_cnt decrements once per cycle; at 1, go to COMMIT.
//   COMMIT: single cycle.
//         - Perform the write or read, register resp_rdata and resp_err.
//         - Set resp_valid=1 and go to RESP.
//   RESP: resp_valid=1, req_ready=0.
//         - resp_rdata and resp_err are held stable.
//         - On resp_ready, clear resp_valid and go to IDLE.
//  Timing:
//   - Accept at edge t gives resp_valid high after edge t+LATENCY+1.
//   - The next accept is possible on the cycle after resp_valid && resp_ready.
//   - Throughput is one request per LATENCY+3 cycles, with resp_ready tied to 1.
//  Addressing:
//   - off = req_addr - BASE_ADDR (32-bit unsigned; wrap below base is out of range).
//   - Word index = off[log2(DEPTH_WORDS)+1:2].
//   - resp_err=1 when off >= 4*DEPTH_WORDS or req_addr[1:0] != 0.
//   - On error: no write, resp_rdata=0.
//  Stores:
//   - Only the bytes whose enable is set are updated; other bytes are kept.
//   - be=4'b0000 is a legal no-op store; resp_err=0.
//   - Each committed store prints: "@%h: *%h <= %h" with
//     (req_pc, word-aligned req_addr, merged word).
//  Loads: always return the full 32-bit word; req_be is ignored.
//  Request/response pairs complete in acceptance order. There is no overlap:
//  the responder never holds two requests at once.
//  req_* inputs are sampled only on the accept edge. Changes after accept
//  have no effect.
// TESTING
//  1. Reset, LATENCY=2; load at 0x0 -> resp_valid 3 edges after accept;
//     rdata=0, err=0.
//  2. Store 0x12345678 be=1111 at 0x10, then store 0xAABBCCDD be=0101 at 0x10,
//     then load 0x10 -> rdata=0x12BB56DD; log shows two lines.
//  3. Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable,
//     req_ready=0 throughout; accept resumes the cycle after the response drains.
//  4. Load at 0x1002 and at 4*DEPTH_WORDS -> err=1, rdata=0;
//     a store there leaves memory unchanged.
//  5. Assert reset during WAIT of a store to 0x20 -> IDLE next cycle;
//     a later load of 0x20 returns 0.
//  6. LATENCY=0; back-to-back store then load at 0x4 with resp_ready=1 ->
//     each response arrives 1 edge after accept; load returns the stored word.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: single-outstanding load/store slave with a programmable
// number of wait states between request accept and response.
module dm_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  fsm_state,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid may not be withdrawn by the sender until that edge, and the
  // response payload is held stable while resp_valid is high.

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic [31:0]   lat_pc;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          addr_err;
  logic [31:0]   cur_word;
  logic [31:0]   merged;

  // Offset arithmetic wraps, so an address below BASE_ADDR lands far above SPAN.
  assign off      = lat_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign addr_err = (off >= SPAN) || (lat_addr[1:0] != 2'b00);
  assign cur_word = mem[idx];

  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (lat_be[b]) merged[8*b +: 8] = lat_wdata[8*b +: 8];
    end
  end

  assign req_ready = (state == S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_be     <= 4'd0;
      lat_wdata  <= 32'd0;
      lat_pc     <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      log_valid  <= 1'b0;
      log_pc     <= 32'd0;
      log_addr   <= 32'd0;
      log_data   <= 32'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      log_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
            lat_pc    <= req_pc;
            wait_cnt  <= 4'(LATENCY);
            state     <= (LATENCY > 0) ? S_WAIT : S_COMMIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= S_COMMIT;
        end
        S_COMMIT: begin
          resp_valid <= 1'b1;
          resp_err   <= addr_err;
          resp_rdata <= (addr_err || lat_we) ? 32'd0 : cur_word;
          if (lat_we && !addr_err) begin
            mem[idx]  <= merged;
            log_valid <= 1'b1;
            log_pc    <= lat_pc;
            log_addr  <= {lat_addr[31:2], 2'b00};
            log_data  <= merged;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
